mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Controller for the shared 64-bit memory port of the pipelined core.
- Arbitrates between the instruction-fetch requester (port 0) and the data-access requester (port 1).
- Drives the select line of the external 64-bit 2:1 mux that routes address and write data onto the port, and sequences the memory request/acknowledge handshake.
- Port 1 has priority, but a starvation counter guarantees fetch progress.

Parameters:
- MAX_CONSEC, 4: maximum consecutive port-1 grants while port 0 is pending; legal range 1..15.
- CNT_W, 32: width of the per-port grant counters.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- req0  input  1  fetch request; held high with stable we0/addr0 until ack0
- we0  input  1  fetch write enable (normally 0)
- req1  input  1  data request; held high with stable we1/addr1/wdata1 until ack1
- we1  input  1  data write enable
- mem_ack  input  1  memory completion, single-cycle pulse, valid only while mem_req=1
- sel  output  1  mux control: 0 routes port 0, 1 routes port 1
- mem_req  output  1  request to memory
- mem_we  output  1  write enable to memory: we0 or we1 per sel
- ack0  output  1  one-cycle completion pulse to port 0; mem_rdata valid this cycle
- ack1  output  1  one-cycle completion pulse to port 1
- busy  output  1  high whenever the FSM is not in IDLE
- grant0_cnt  output  CNT_W  total grants issued to port 0, wraps
- grant1_cnt  output  CNT_W  total grants issued to port 1, wraps

Behaviour:
- Reset values:
  - Reset is asynchronous: all outputs go low or zero immediately.
  - FSM enters IDLE; starve_cnt = 0; sel = 0.
- FSM states: IDLE, BUSY, DONE.
  - **IDLE:**
    - If neither request is high, stay in IDLE.
    - Otherwise select a winner, register sel, go to BUSY, and increment that port's grant counter.
  - **BUSY:**
    - mem_req = 1; mem_we = sel ? we1 : we0 (combinational from the held inputs).
    - On mem_ack = 1, go to DONE.
    - sel is frozen while in BUSY.
  - **DONE:**
    - mem_req = 0; ack[sel] = 1 for exactly this cycle.
    - No arbitration in this cycle, because the requester drops req on the following edge.
    - Next state is IDLE.
- Winner selection in IDLE:
  - Only req0 high: grant port 0.
  - Only req1 high: grant port 1.
  - Both high: grant port 0 if starve_cnt == MAX_CONSEC, else grant port 1.
- starve_cnt (width 4):
  - Increments on a port-1 grant while req0 = 1.
  - Clears on any port-0 grant.
  - Clears on a port-1 grant while req0 = 0.
  - Saturates at MAX_CONSEC.
- Latency:
  - A request sampled in IDLE at edge N gives mem_req high from cycle N+1.
  - An ack pulse follows one cycle after the mem_ack cycle.
  - Minimum turnaround is 3 cycles (IDLE → BUSY → DONE → IDLE); back-to-back grants are therefore spaced at least 3 cycles apart.
- sel holds its last value in IDLE and DONE; it changes only on a grant edge.
- Boundary conditions:
  - mem_ack in IDLE or DONE: ignored.
  - req withdrawn during BUSY (protocol violation): the transaction still completes and ack still pulses; no abort.
  - Grant counters wrap from 2^CNT_W−1 to 0 with no flag.
  - Reset asserted mid-BUSY: mem_req drops asynchronously, no ack is issued, and the requester must re-request.
  - New requests arriving during BUSY or DONE: queued implicitly, because req is level-held; they are evaluated in the next IDLE.

Test Plan:
- Single port-0 read: req0=1, we0=0 at cycle 0, mem_ack on cycle 2 → sel=0; mem_req high on cycles 1-2; ack0 on cycle 3; busy high on cycles 1-3; grant0_cnt=1.
- Simultaneous requests, req1 only briefly: req0 and req1 high together, req1 dropped after its ack → port 1 granted first (sel=1, mem_we=we1); port 0 granted at the next IDLE; ack1 precedes ack0.
- Starvation limit: both requesters continuously high, MAX_CONSEC=4, mem_ack one cycle after each mem_req → grant sequence 1,1,1,1,0,1,1,1,1,0; starve_cnt returns to 0 after each port-0 grant.
- Stray ack and reset mid-transaction:
  - mem_ack pulsed while IDLE → no ack0/ack1, no state change.
  - rst asserted mid-BUSY between clock edges → mem_req, busy and sel read 0 before the next edge; no ack afterwards.
- Counter wrap: with CNT_W=4, issue 17 port-1 transactions → grant1_cnt reads 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter and handshake sequencer for the shared 64-bit memory port.
// Data port (1) wins ties; a starvation counter forces a fetch grant after MAX_CONSEC data grants.
module mem_port_arbiter #(
  parameter int MAX_CONSEC = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic             req1,
  input  logic             we1,
  input  logic             mem_ack,
  output logic             sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] L_MAX = 4'(MAX_CONSEC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel;
  logic [3:0]       r_starve_cnt;
  logic [CNT_W-1:0] r_grant0_cnt;
  logic [CNT_W-1:0] r_grant1_cnt;

  logic             w_grant;
  logic             w_win1;
  logic             w_starved;

  // Fetch is forced only when both request and the data port has used its quota.
  assign w_starved = req0 && (r_starve_cnt == L_MAX);
  assign w_win1    = req1 && !w_starved;
  assign w_grant   = (r_state == IDLE) && (req0 || req1);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req0 || req1) w_state_nxt = BUSY;
      BUSY:    if (mem_ack)      w_state_nxt = DONE;
      DONE:                      w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // sel changes only on a grant edge and stays frozen through BUSY and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 1'b0;
    end else if (w_grant) begin
      r_sel <= w_win1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant) begin
      if (!w_win1 || !req0) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt != L_MAX) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // Grant counters wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant0_cnt <= '0;
      r_grant1_cnt <= '0;
    end else if (w_grant) begin
      if (w_win1) begin
        r_grant1_cnt <= r_grant1_cnt + 1'b1;
      end else begin
        r_grant0_cnt <= r_grant0_cnt + 1'b1;
      end
    end
  end

  assign sel        = r_sel;
  assign busy       = (r_state != IDLE);
  assign mem_req    = (r_state == BUSY);
  assign mem_we     = (r_state == BUSY) && (r_sel ? we1 : we0);
  assign ack0       = (r_state == DONE) && !r_sel;
  assign ack1       = (r_state == DONE) &&  r_sel;
  assign grant0_cnt = r_grant0_cnt;
  assign grant1_cnt = r_grant1_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, tie-break, starvation, stray ack,
// async reset mid-transaction and grant-counter wrap (CNT_W=4).
module tb_mem_port_arbiter;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, we0, req1, we1, mem_ack;
  logic             sel, mem_req, mem_we, ack0, ack1, busy;
  logic [CNT_W-1:0] grant0_cnt, grant1_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.MAX_CONSEC(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .we0        (we0),
    .req1       (req1),
    .we1        (we1),
    .mem_ack    (mem_ack),
    .sel        (sel),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ack0       (ack0),
    .ack1       (ack1),
    .busy       (busy),
    .grant0_cnt (grant0_cnt),
    .grant1_cnt (grant1_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive and sample 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; req0 = 0; we0 = 0; req1 = 0; we1 = 0; mem_ack = 0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_g0", grant0_cnt, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single port-0 read: cycle 0 request, mem_ack in cycle 2, ack0 in cycle 3.
    req0 = 1; we0 = 0;
    check("t1_c0_busy", busy, 0);
    tick();
    check("t1_c1_mem_req", mem_req, 1);
    check("t1_c1_sel", sel, 0);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_mem_we", mem_we, 0);
    check("t1_c1_g0", grant0_cnt, 1);
    tick();
    check("t1_c2_mem_req", mem_req, 1);
    check("t1_c2_ack0", ack0, 0);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("t1_c3_ack0", ack0, 1);
    check("t1_c3_ack1", ack1, 0);
    check("t1_c3_mem_req", mem_req, 0);
    check("t1_c3_busy", busy, 1);
    req0 = 0;
    tick();
    check("t1_c4_busy", busy, 0);
    check("t1_c4_ack0", ack0, 0);

    // Simultaneous requests: port 1 first, then port 0.
    req0 = 1; we0 = 0; req1 = 1; we1 = 1;
    tick();
    check("t2_sel1", sel, 1);
    check("t2_mem_we1", mem_we, 1);
    check("t2_g1", grant1_cnt, 1);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("t2_ack1", ack1, 1);
    check("t2_ack0_early", ack0, 0);
    req1 = 0;
    tick();
    check("t2_idle", busy, 0);
    check("t2_sel_hold", sel, 1);
    tick();
    check("t2_sel0", sel, 0);
    check("t2_mem_we0", mem_we, 0);
    check("t2_g0", grant0_cnt, 2);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("t2_ack0", ack0, 1);
    req0 = 0;
    tick();

    // Starvation: both requesters held high for ten grants.
    req0 = 1; req1 = 1; we1 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t3_sel_%0d", i), sel, 32'(exp_seq[i]));
      tick();
      mem_ack = 1;
      tick();
      mem_ack = 0;
      check($sformatf("t3_ack_%0d", i), {ack1, ack0}, exp_seq[i] ? 32'd2 : 32'd1);
      if (i == 9) begin
        req0 = 0; req1 = 0;
      end
      tick();
    end
    check("t3_g0", grant0_cnt, 4);
    check("t3_g1", grant1_cnt, 9);

    // Stray ack in IDLE is ignored.
    mem_ack = 1;
    tick();
    check("t4_stray_busy", busy, 0);
    check("t4_stray_acks", {ack1, ack0}, 0);
    check("t4_stray_mem_req", mem_req, 0);
    mem_ack = 0;
    tick();
    check("t4_stray_busy2", busy, 0);

    // Reset asserted mid-BUSY between edges.
    req1 = 1; we1 = 0;
    tick();
    check("t5_busy_pre", mem_req, 1);
    check("t5_sel_pre", sel, 1);
    #2 rst = 1;
    #1;
    check("t5_rst_mem_req", mem_req, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sel", sel, 0);
    check("t5_rst_g1", grant1_cnt, 0);
    #1 rst = 0; req1 = 0;
    tick();
    check("t5_after_acks", {ack1, ack0}, 0);
    check("t5_after_busy", busy, 0);
    tick();
    check("t5_after_acks2", {ack1, ack0}, 0);

    // Counter wrap: 17 port-1 transactions on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      req1 = 1;
      tick();
      mem_ack = 1;
      tick();
      mem_ack = 0;
      req1 = 0;
      if (i == 15) check("t6_g1_wrap0", grant1_cnt, 0);
      tick();
    end
    check("t6_g1_wrap1", grant1_cnt, 1);
    check("t6_g0", grant0_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
